// File: rtl/ring_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ring_buffer_arbiter
// Description : Round-robin, burst-holding arbiter in front of a ring buffer's
//               write port; one producer owns the buffer for a whole burst.
// Revision    : 1.0
// ============================================================================
module ring_buffer_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int N_PORTS   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_PORTS-1:0]             req_rx_i,
    input  logic [N_PORTS-1:0]             req_last_i,
    input  logic [N_PORTS*DATA_SIZE-1:0]   req_data_i,
    output logic [N_PORTS-1:0]             req_rx_ack_o,
    output logic                           rx_o,
    input  logic                           rx_ack_i,
    output logic [DATA_SIZE-1:0]           data_o,
    output logic [$clog2(N_PORTS)-1:0]     grant_o,
    output logic                           busy_o
);

    localparam int c_IDX_W  = $clog2(N_PORTS);
    localparam int c_SUM_W  = c_IDX_W + 1;
    localparam int c_BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_PORT = c_IDX_W'(N_PORTS - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_CAP  = c_BEAT_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_IDX_W-1:0]    r_owner;
    logic [c_IDX_W-1:0]    r_ptr;
    logic [c_BEAT_W-1:0]   r_beats;

    logic                  w_found;
    logic [c_IDX_W-1:0]    w_pick;
    logic [c_SUM_W-1:0]    w_sum;
    logic                  w_grant;
    logic                  w_owner_req;
    logic                  w_owner_last;
    logic                  w_xfer;
    logic                  w_burst_end;
    logic [c_IDX_W-1:0]    w_next_ptr;

    // First requester at or after r_ptr, wrapping modulo N_PORTS (not a power of 2 in general).
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_sum   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_sum = {1'b0, r_ptr} + c_SUM_W'(i);
            if (w_sum >= c_SUM_W'(N_PORTS)) begin
                w_sum = w_sum - c_SUM_W'(N_PORTS);
            end
            if (!w_found && req_rx_i[w_sum[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_grant      = (r_state == S_GRANT);
    assign w_owner_req  = req_rx_i[r_owner];
    assign w_owner_last = req_last_i[r_owner];
    assign w_xfer       = w_grant && w_owner_req && rx_ack_i;
    assign w_burst_end  = w_xfer && (w_owner_last || (r_beats == c_BEAT_CAP));
    assign w_next_ptr   = (r_owner == c_LAST_PORT) ? '0 : r_owner + 1'b1;

    assign rx_o    = w_grant && w_owner_req;
    assign data_o  = w_grant ? req_data_i[r_owner*DATA_SIZE +: DATA_SIZE] : '0;
    assign grant_o = r_owner;
    assign busy_o  = w_grant;

    // Only the owner ever sees an accept; it follows buffer readiness directly.
    always_comb begin
        req_rx_ack_o = '0;
        if (w_grant) begin
            req_rx_ack_o[r_owner] = rx_ack_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_beats <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_beats <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_burst_end) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else if (w_xfer) begin
                        r_beats <= r_beats + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
